pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
Parametrised, pipelined signed adder/subtractor with a valid/ready handshake and a full flag set (C, V, N, Z). Next-generation ALU arithmetic unit for the pipelined processor. The operand width is split into STAGES equal chunks; each stage resolves one chunk and registers the carry into the next. Sits in the execute stage and feeds the condition-code register and writeback.

Parameters:
WIDTH, 64, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; range 1..WIDTH.
TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
flush  in  1  synchronous clear of all in-flight operations
in_valid  in  1  operation presented
in_ready  out  1  unit can accept an operation this cycle
in_op  in  1  0 = add, 1 = subtract (a - b)
in_a  in  WIDTH  signed operand a
in_b  in  WIDTH  signed operand b
in_tag  in  TAG_W  sideband tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_sum  out  WIDTH  result
out_tag  out  TAG_W  tag of the result
out_c  out  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
out_v  out  1  signed overflow: carry into MSB xor carry out of MSB
out_n  out  1  out_sum[WIDTH-1]
out_z  out  1  out_sum == 0

Behaviour:
- Accept/transfer: an operation is accepted when in_valid && in_ready; a result transfers when out_valid && out_ready.
- Global enable: en = !(out_valid && !out_ready). in_ready = en && !flush. All stage registers advance only when en is high.
- Subtract: b is inverted and carry-in forced to 1. Add: carry-in is 0.
- Stage k (0..STAGES-1) adds chunk k of a and b with the registered carry from stage k-1. It registers the sum chunk, carry, op, tag and the still-unconsumed upper operand chunks. Lower result chunks are skewed forward.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput: 1 operation per cycle. Results emerge in acceptance order.
- Flags are computed in the final stage and are registered with out_sum. The MSB carry-in is kept so that out_v is exact.
- Stall: while out_valid && !out_ready, out_sum, out_tag and all flags hold stable. No operation is lost or duplicated.
- Bubbles: invalid slots propagate as bubbles. There is no bubble collapse; the stall is global.
- flush: clears every stage valid bit on the next edge. Data registers may be left unchanged. An input presented in the same cycle is not accepted. flush takes priority over out_ready; the result visible that cycle is discarded if not already handshaken.
- Reset (rst_n low at an edge): all valid bits cleared. out_valid=0, out_sum=0, out_tag=0, out_c=out_v=out_n=0, out_z=0. in_ready=1 in the first cycle after reset is released. Reset mid-operation discards all in-flight work.
- Wrap-around: without the saturating feature, results wrap modulo 2^WIDTH.
- STAGES=1 degenerates to a single registered full-width add/subtract.
- Elaboration error if WIDTH % STAGES != 0.

Optional Feature:
PIPE_ADDSUB_SAT_EN:
- When defined, a signed overflow clamps out_sum: to 2^(WIDTH-1)-1 if a positive result overflowed, or to -2^(WIDTH-1) if a negative one did.
- out_v still reports the overflow. out_n and out_z reflect the clamped value. out_c is unchanged (raw carry).
- When undefined, out_sum wraps and no clamp logic is generated.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants ALU_ADD=1'b0 and ALU_SUB=1'b1;
  - a flags struct/typedef {c,v,n,z};
  - a helper function for the saturation limits.
- One sub-module, addsub_chunk: a combinational CW-bit adder with carry-in, carry-out and MSB carry-in output, instantiated once per stage via generate.

Test Plan:
1. WIDTH=64, STAGES=4, add 0x000000000000FFFF + 0x1 -> 0x0000000000010000 after exactly 4 cycles; C=0, V=0, Z=0. Exercises the carry across a chunk boundary.
2. Add 0x7FFFFFFFFFFFFFFF + 0x1 -> 0x8000000000000000 with V=1, N=1, C=0. With PIPE_ADDSUB_SAT_EN the result is 0x7FFFFFFFFFFFFFFF with V=1, N=0.
3. Subtract 5 - 7 -> 0xFFFFFFFFFFFFFFFE with C=0, N=1, V=0. Subtract 7 - 7 -> 0 with Z=1, C=1.
4. Stream 8 back-to-back ops with tags 0..7 and hold out_ready low for 3 cycles mid-stream. in_ready drops, outputs stay stable, and all 8 results emerge in tag order with no loss.
5. With 3 ops in flight, assert flush for 1 cycle alongside in_valid. No results emerge, that input is not accepted, and the next op arrives after 4 cycles.
6. Drop rst_n for 1 cycle with a full pipeline. The next cycle shows out_valid=0 with all outputs 0 and in_ready=1; a subsequent op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, flag bundle and saturation helper shared by the ALU arithmetic units
package alu_pkg;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;
  typedef struct packed {
    logic msb;
    logic fill;
  } sat_t;
  // A wrapped result with MSB set came from positive overflow, so clamp to max; otherwise to min
  function automatic sat_t sat_limit(input logic raw_msb);
    return '{msb: !raw_msb, fill: raw_msb};
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CW-bit adder with carry-in, carry-out and carry into the chunk MSB
module addsub_chunk #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          cm
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
  assign cm = a[CW-1] ^ b[CW-1] ^ s[CW-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: chunk-pipelined signed add/subtract with valid/ready handshake and C/V/N/Z flags
// Define PIPE_ADDSUB_SAT_EN to clamp signed overflow to the representable limits.
module pipe_addsub import alu_pkg::*; #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_v,
  output logic             out_n,
  output logic             out_z
);
  localparam int CW = WIDTH / STAGES;
  if (WIDTH % STAGES != 0) begin : g_bad
    $error("pipe_addsub: WIDTH must be divisible by STAGES");
  end
  logic             en;
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] d_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [TAG_W-1:0] t_q [STAGES];
  flags_t           f_q;
  assign en = !(out_valid && !out_ready);
  assign in_ready = en && !flush;
  // d carries finished sum chunks below stage k and unconsumed a chunks above; b shifts down one chunk per stage
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] d_i, b_i, d_n, d_r;
    logic [TAG_W-1:0] t_i;
    logic             c_i, vi, co, cm;
    logic [CW-1:0]    s;
    if (k == 0) begin : g_in
      assign d_i = in_a;
      assign b_i = (in_op == ALU_ADD) ? in_b : ~in_b;
      assign c_i = (in_op == ALU_SUB);
      assign vi  = in_valid && in_ready;
      assign t_i = in_tag;
    end else begin : g_link
      assign d_i = d_q[k-1];
      assign b_i = b_q[k-1];
      assign c_i = c_q[k-1];
      assign vi  = v_q[k-1];
      assign t_i = t_q[k-1];
    end
    addsub_chunk #(.CW(CW)) u_chunk (
      .a (d_i[k*CW +: CW]),
      .b (b_i[CW-1:0]),
      .ci(c_i),
      .s (s),
      .co(co),
      .cm(cm)
    );
    always_comb begin
      d_n = d_i;
      d_n[k*CW +: CW] = s;
    end
    if (k == STAGES-1) begin : g_out
      logic ovf, unused;
      logic [WIDTH-1:0] res;
      assign ovf = cm ^ co;
      assign unused = ^{b_q[k], c_q[k]};
`ifdef PIPE_ADDSUB_SAT_EN
      sat_t lim;
      assign lim = sat_limit(d_n[WIDTH-1]);
      assign res = ovf ? {lim.msb, {(WIDTH-1){lim.fill}}} : d_n;
`else
      assign res = d_n;
`endif
      assign d_r = res;
      always_ff @(posedge clk)
        if (!rst_n) f_q <= '0;
        else if (en) f_q <= '{c: co, v: ovf, n: res[WIDTH-1], z: (res == '0)};
    end else begin : g_mid
      logic unused;
      assign unused = cm;
      assign d_r = d_n;
    end
    always_ff @(posedge clk)
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        d_q[k] <= '0;
        b_q[k] <= '0;
        t_q[k] <= '0;
      end else begin
        v_q[k] <= flush ? 1'b0 : en ? vi : v_q[k];
        if (en) begin
          c_q[k] <= co;
          d_q[k] <= d_r;
          b_q[k] <= b_i >> CW;
          t_q[k] <= t_i;
        end
      end
  end
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = d_q[STAGES-1];
  assign out_tag   = t_q[STAGES-1];
  assign out_c     = f_q.c;
  assign out_v     = f_q.v;
  assign out_n     = f_q.n;
  assign out_z     = f_q.z;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed vector table plus stall, flush and reset sequences for pipe_addsub
module tb_pipe_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_c, out_v, out_n, out_z;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic [3:0]  f;
  } vec_t;
  vec_t vt [10];

  pipe_addsub #(.WIDTH(64), .STAGES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag),
    .out_c(out_c), .out_v(out_v), .out_n(out_n), .out_z(out_z)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic [63:0] a, b, sum, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sum = sum; v.f = f;
    return v;
  endfunction

  function automatic logic [63:0] sa(input int i);
    return 64'(i) * 64'h0000_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] sb(input int i);
    return 64'(i + 1) * 64'h0000_0000_0001_0001;
  endfunction

  task automatic check_idle(input string name);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_sum"}, out_sum, 64'd0);
    chk({name, "_out_tag"}, 64'(out_tag), 64'd0);
    chk({name, "_flags"}, 64'({out_c, out_v, out_n, out_z}), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input int idx, input logic [3:0] tag);
    vec_t v;
    int cyc;
    v = vt[idx];
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_tag = tag;
    #1;
    chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'd4);
    chk($sformatf("v%0d_sum", idx), out_sum, v.sum);
    chk($sformatf("v%0d_flags_cvnz", idx), 64'({out_c, out_v, out_n, out_z}), 64'(v.f));
    chk($sformatf("v%0d_tag", idx), 64'(out_tag), 64'(tag));
  endtask

  task automatic stream_test();
    logic [63:0] snap_s;
    logic [3:0]  snap_t;
    int sent, got;
    sent = 0; got = 0; snap_s = '0; snap_t = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid = (sent < 8);
      in_op = 1'b0; in_a = sa(sent); in_b = sb(sent); in_tag = sent[3:0];
      #1;
      if (cyc == 6) begin
        snap_s = out_sum;
        snap_t = out_tag;
        chk("stall_out_valid", 64'(out_valid), 64'd1);
      end
      if (cyc >= 6 && cyc <= 8) chk($sformatf("stall_in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
      if (cyc >= 7 && cyc <= 9) begin
        chk($sformatf("stall_sum_c%0d", cyc), out_sum, snap_s);
        chk($sformatf("stall_tag_c%0d", cyc), 64'(out_tag), 64'(snap_t));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream_tag_%0d", got), 64'(out_tag), 64'(got));
        chk($sformatf("stream_sum_%0d", got), out_sum, sa(got) + sb(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'd8);
  endtask

  task automatic flush_test();
    int seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b0; in_a = 64'(i); in_b = 64'd1; in_tag = 4'(i + 1);
    end
    @(negedge clk);
    in_tag = 4'h9; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_results", 64'(seen), 64'd0);
    run_vec(0, 4'hA);
  endtask

  task automatic reset_test();
    int seen;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b0; in_a = 64'(i + 3); in_b = 64'd7; in_tag = 4'(i + 4);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("midrst");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_results", 64'(seen), 64'd0);
    run_vec(6, 4'h5);
  endtask

  initial begin
    vt[0] = mk(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 4'b0000);
    vt[1] = mk(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0110);
    vt[2] = mk(1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
    vt[3] = mk(1'b1, 64'd7, 64'd7, 64'h0, 4'b1001);
    vt[4] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1001);
    vt[5] = mk(1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    vt[6] = mk(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h1234_5678_9ABC_DF00, 4'b0000);
    vt[7] = mk(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1001);
    vt[8] = mk(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1101);
    vt[9] = mk(1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
`ifdef PIPE_ADDSUB_SAT_EN
    vt[1].sum = 64'h7FFF_FFFF_FFFF_FFFF; vt[1].f = 4'b0100;
    vt[5].sum = 64'h8000_0000_0000_0000; vt[5].f = 4'b1110;
    vt[8].sum = 64'h8000_0000_0000_0000; vt[8].f = 4'b1110;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("reset");
    for (int i = 0; i < 10; i++) run_vec(i, 4'(i));
    stream_test();
    flush_test();
    reset_test();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
